// File: rtl/sync_fifo_ctrl.sv
// First-word-fall-through FIFO controller for an external RAM with a registered read port.
// Optional almost-full/almost-empty outputs: define SYNC_FIFO_CTRL_WMARK_EN.
module sync_fifo_ctrl #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_wvalid,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_wready,
    output logic              o_rvalid,
    output logic [DATA_W-1:0] o_rdata,
    input  logic              i_rready,
    output logic [ADDR_W:0]   o_count,
    output logic              o_ram_wren,
    output logic [ADDR_W-1:0] o_ram_waddr,
    output logic [DATA_W-1:0] o_ram_wdata,
    output logic [ADDR_W-1:0] o_ram_raddr,
    input  logic [DATA_W-1:0] i_ram_rdata
`ifdef SYNC_FIFO_CTRL_WMARK_EN
    ,
    output logic              o_almost_full,
    output logic              o_almost_empty
`endif
);

    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_rvalid;

    logic              w_push;
    logic              w_pop;
    logic [CW-1:0]     w_push_ext;
    logic [CW-1:0]     w_pop_ext;
    logic [CW-1:0]     w_count_next;
    logic              w_rvalid_next;
    logic [ADDR_W-1:0] w_rd_ptr_inc;

    assign o_wready     = (r_count != FULL_CNT);
    assign w_push       = i_wvalid & o_wready;
    assign w_pop        = r_rvalid & i_rready;
    assign w_push_ext   = {{ADDR_W{1'b0}}, w_push};
    assign w_pop_ext    = {{ADDR_W{1'b0}}, w_pop};
    assign w_rd_ptr_inc = r_rd_ptr + ADDR_W'(1);

    assign w_count_next  = r_count + w_push_ext - w_pop_ext;
    // Only entries written before this cycle count, so a same-cycle write is never read early.
    assign w_rvalid_next = ((r_count - w_pop_ext) != '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            r_count  <= w_count_next;
            r_rvalid <= w_rvalid_next;
        end
    end

    assign o_rvalid    = r_rvalid;
    assign o_rdata     = i_ram_rdata;
    assign o_count     = r_count;
    assign o_ram_wren  = w_push;
    assign o_ram_waddr = r_wr_ptr;
    assign o_ram_wdata = i_wdata;
    // Look one slot ahead on a pop so the following head lands right after the RAM latency.
    assign o_ram_raddr = w_pop ? w_rd_ptr_inc : r_rd_ptr;

`ifdef SYNC_FIFO_CTRL_WMARK_EN
    assign o_almost_full  = (r_count >= CW'(AF_LEVEL));
    assign o_almost_empty = (r_count <= CW'(AE_LEVEL));
`else
    logic w_unused_wmark;
    assign w_unused_wmark = ^{AF_LEVEL[0], AE_LEVEL[0]};
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl with a behavioural registered-read RAM and an expected-data queue.
module tb_sync_fifo_ctrl;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int AF     = DEPTH - 2;
    localparam int AE     = 1;

    logic              clk = 1'b0;
    logic              rstn;
    logic              i_wvalid;
    logic [DATA_W-1:0] i_wdata;
    logic              o_wready;
    logic              o_rvalid;
    logic [DATA_W-1:0] o_rdata;
    logic              i_rready;
    logic [ADDR_W:0]   o_count;
    logic              o_ram_wren;
    logic [ADDR_W-1:0] o_ram_waddr;
    logic [DATA_W-1:0] o_ram_wdata;
    logic [ADDR_W-1:0] o_ram_raddr;
    logic [DATA_W-1:0] i_ram_rdata;
`ifdef SYNC_FIFO_CTRL_WMARK_EN
    logic              o_almost_full;
    logic              o_almost_empty;
`endif

    int tests = 0;
    int fails = 0;

    int          m_count;
    logic        m_rvalid;
    int          m_wptr;
    logic [7:0]  exp_q[$];

    logic [DATA_W-1:0] mem [DEPTH];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_ram_wren) mem[o_ram_waddr] <= o_ram_wdata;
        i_ram_rdata <= mem[o_ram_raddr];
    end

    sync_fifo_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_wvalid    (i_wvalid),
        .i_wdata     (i_wdata),
        .o_wready    (o_wready),
        .o_rvalid    (o_rvalid),
        .o_rdata     (o_rdata),
        .i_rready    (i_rready),
        .o_count     (o_count),
        .o_ram_wren  (o_ram_wren),
        .o_ram_waddr (o_ram_waddr),
        .o_ram_wdata (o_ram_wdata),
        .o_ram_raddr (o_ram_raddr),
        .i_ram_rdata (i_ram_rdata)
`ifdef SYNC_FIFO_CTRL_WMARK_EN
        ,
        .o_almost_full  (o_almost_full),
        .o_almost_empty (o_almost_empty)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_count  = 0;
        m_rvalid = 1'b0;
        m_wptr   = 0;
        exp_q.delete();
    endtask

    task automatic check_idle_outputs();
        check("wready", 32'(o_wready), 32'(m_count != DEPTH));
        check("rvalid", 32'(o_rvalid), 32'(m_rvalid));
        check("count", 32'(o_count), 32'(m_count));
`ifdef SYNC_FIFO_CTRL_WMARK_EN
        check("almost_full", 32'(o_almost_full), 32'(m_count >= AF));
        check("almost_empty", 32'(o_almost_empty), 32'(m_count <= AE));
`endif
    endtask

    // One clock cycle: drive, sample at the falling edge, then advance the model at the rising edge.
    task automatic step(input logic wv, input logic [7:0] wd, input logic rr);
        logic push_m;
        logic pop_m;
        i_wvalid = wv;
        i_wdata  = wd;
        i_rready = rr;
        push_m = wv && (m_count != DEPTH);
        pop_m  = m_rvalid && rr;
        @(negedge clk);
        check_idle_outputs();
        check("wren", 32'(o_ram_wren), 32'(push_m));
        check("waddr", 32'(o_ram_waddr), 32'(m_wptr % DEPTH));
        if (m_rvalid && exp_q.size() > 0) check("rdata", 32'(o_rdata), 32'(exp_q[0]));
        @(posedge clk);
        m_rvalid = ((m_count - int'(pop_m)) != 0);
        m_count  = m_count + int'(push_m) - int'(pop_m);
        if (pop_m) begin
            $display("[TB] pop  %02h count=%0d", exp_q[0], m_count);
            void'(exp_q.pop_front());
        end
        if (push_m) begin
            exp_q.push_back(wd);
            m_wptr++;
            $display("[TB] push %02h count=%0d", wd, m_count);
        end
        #1;
    endtask

    initial begin
        rstn     = 1'b0;
        i_wvalid = 1'b0;
        i_wdata  = '0;
        i_rready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs();
        rstn = 1'b1;

        // Single push into empty FIFO, head held with rready low
        step(1'b1, 8'hA5, 1'b0);
        repeat (4) step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Fill to full, then a rejected ninth push
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b1, 8'h99, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        // Drain at one word per cycle, then rready on an empty FIFO
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Hold count at 4 with simultaneous push/pop across pointer wrap
        for (int i = 0; i < 4; i++) step(1'b1, 8'h40 + 8'(i), 1'b0);
        step(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 8'h80 + 8'(i), 1'b1);

        // Down to count 1, then push+pop together
        repeat (3) step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h3C, 1'b1);
        repeat (2) step(1'b0, 8'h00, 1'b0);

        // Full with a pop: the write is refused this cycle and taken the next
        for (int i = 0; i < DEPTH - 1; i++) step(1'b1, 8'hD0 + 8'(i), 1'b0);
        step(1'b1, 8'h55, 1'b1);
        step(1'b1, 8'h55, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Reach count 5, then reset asynchronously between edges
        for (int i = 0; i < 5; i++) step(1'b1, 8'h60 + 8'(i), 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("count_pre_reset", 32'(o_count), 32'd5);
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check_idle_outputs();
        @(negedge clk);
        check_idle_outputs();
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Normal operation after reset
        step(1'b1, 8'hC3, 1'b0);
        repeat (2) step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
